// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared fetch-state encodings and redirect helper
//
// Holds the fetch state machine encoding and the redirect-target selection
// used by inst_fetcher. No ports; imported with import inst_fetcher_pkg::*.
package inst_fetcher_pkg;

  typedef enum logic [1:0] {
    fetch_state_req   = 2'd0,  // request strobe out this cycle
    fetch_state_wait  = 2'd1,  // one request outstanding, response wanted
    fetch_state_hold  = 2'd2,  // instruction presented to the decoder
    fetch_state_drain = 2'd3   // one request outstanding, response discarded
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // ROB flush carries the architecturally correct path, so it beats a
  // decoder steer raised in the same cycle. Targets are word aligned.
  function automatic logic [31:0] redirect_target(
    input logic        rob_flush,
    input logic [31:0] rob_flush_pc,
    input logic [31:0] if_addr
  );
    logic [31:0] sel;
    sel = rob_flush ? rob_flush_pc : if_addr;
    return {sel[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch unit feeding the decoder
//
// Owns the fetch PC, issues one word request at a time to the icache and
// presents each returned instruction with a valid/consume handshake.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global enable; low freezes all state and requests
//   ic_req, ic_addr    icache request strobe and word address (combinational)
//   ic_resp, ic_data   icache response strobe and instruction word
//   inst_valid         instruction presented to the decoder
//   inst_pc, inst_data PC and word of the presented instruction
//   need_inst          low = decoder consumes the presented instruction
//   clear_inst, if_addr       decoder redirect strobe and target
//   rob_flush, rob_flush_pc   ROB mispredict flush and correct-path PC
import inst_fetcher_pkg::*;

module inst_fetcher #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_resp,
  input  logic [31:0] ic_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        need_inst,
  input  logic        clear_inst,
  input  logic [31:0] if_addr,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         inst_valid_n;
  logic [31:0]  inst_pc_n, inst_data_n;

  logic         redirect;
  logic [31:0]  target;
  logic         consume;

  assign redirect = clear_inst | rob_flush;
  assign target   = redirect_target(rob_flush, rob_flush_pc, if_addr);
  assign consume  = inst_valid & ~need_inst;

  // The icache accepts the strobe in the same cycle, so it must stay low
  // while reset is held even though the reset state is REQ.
  assign ic_req  = ~rst & rdy & (state == fetch_state_req);
  assign ic_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= fetch_state_req;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_pc    <= 32'h0;
      inst_data  <= 32'h0;
    end else if (rdy) begin
      state      <= state_n;
      pc         <= pc_n;
      inst_valid <= inst_valid_n;
      inst_pc    <= inst_pc_n;
      inst_data  <= inst_data_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_valid_n = inst_valid;
    inst_pc_n    = inst_pc;
    inst_data_n  = inst_data;

    case (state)
      fetch_state_req: begin
        // The request leaves this cycle regardless; a redirect means its
        // response is already stale and must be drained.
        if (redirect) begin
          pc_n    = target;
          state_n = fetch_state_drain;
        end else begin
          state_n = fetch_state_wait;
        end
      end

      fetch_state_wait: begin
        if (redirect) begin
          pc_n    = target;
          // A response in the same cycle retires the outstanding request,
          // so the target can be fetched straight away.
          state_n = ic_resp ? fetch_state_req : fetch_state_drain;
        end else if (ic_resp) begin
          inst_data_n  = ic_data;
          inst_pc_n    = pc;
          inst_valid_n = 1'b1;
          state_n      = fetch_state_hold;
        end
      end

      fetch_state_hold: begin
        if (redirect) begin
          pc_n         = target;
          inst_valid_n = 1'b0;
          state_n      = fetch_state_req;
        end else if (consume) begin
          pc_n         = pc + PC_STEP;
          inst_valid_n = 1'b0;
          state_n      = fetch_state_req;
        end
      end

      fetch_state_drain: begin
        if (redirect) begin
          pc_n = target;
        end
        if (ic_resp) begin
          state_n = fetch_state_req;
        end
      end

      default: begin
        state_n = fetch_state_req;
      end
    endcase
  end

endmodule
